// File: rtl/divisor_radix_hs.sv
// divisor_radix_hs: sequential restoring integer divider, signed or unsigned per
// transaction, RADIX_BITS quotient bits per cycle, valid/ready on both sides.
// Optional macro DIV_ERR_FLAGS_EN: divide-by-zero / signed-overflow fast path
// with DivZero and Ovf flags; without it both flags read 0.
module divisor_radix_hs #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Num,
  input  logic [WIDTH-1:0] Den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Coc,
  output logic [WIDTH-1:0] Res,
  output logic             DivZero,
  output logic             Ovf
);

  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CONT_INIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cont_q, cont_d;
  logic              sgn_q, sgn_d, snum_q, snum_d, sden_q, sden_d;
  logic [WIDTH:0]    accu_q, accu_d, m_q, m_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  coc_q, coc_d, res_q, res_d;
  logic [WIDTH:0]    step_accu;
  logic [WIDTH-1:0]  step_quo;
  logic              accept;

  // Two's-complement negation, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Magnitude of an operand; raw value when unsigned. |most-negative| wraps to
  // 2^(WIDTH-1), which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? neg2c(v) : v;
  endfunction

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Coc       = coc_q;
  assign Res       = res_q;

`ifdef DIV_ERR_FLAGS_EN
  logic divz_q, divz_d, ovf_q, ovf_d;
  assign DivZero = divz_q;
  assign Ovf     = ovf_q;
`else
  assign DivZero = 1'b0;
  assign Ovf     = 1'b0;
`endif

  // RADIX_BITS chained restoring steps on {ACCU,Q} against divisor M.
  always_comb begin
    step_accu = accu_q;
    step_quo  = quo_q;
    for (int i = 0; i < RADIX_BITS; i++) begin
      step_accu = {step_accu[WIDTH-1:0], step_quo[WIDTH-1]};
      step_quo  = {step_quo[WIDTH-2:0], 1'b0};
      if (step_accu >= m_q) begin
        step_accu   = step_accu - m_q;
        step_quo[0] = 1'b1;
      end
    end
  end

  // Next-state and datapath update for IDLE/CALC/FIX/DONE.
  always_comb begin
    state_d = state_q;
    cont_d  = cont_q;
    sgn_d   = sgn_q;
    snum_d  = snum_q;
    sden_d  = sden_q;
    accu_d  = accu_q;
    m_d     = m_q;
    quo_d   = quo_q;
    coc_d   = coc_q;
    res_d   = res_q;
`ifdef DIV_ERR_FLAGS_EN
    divz_d  = divz_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sgn_d   = Signed;
          snum_d  = Signed && Num[WIDTH-1];
          sden_d  = Signed && Den[WIDTH-1];
          accu_d  = '0;
          quo_d   = mag(Num, Signed);
          m_d     = {1'b0, mag(Den, Signed)};
          cont_d  = CONT_INIT;
          state_d = CALC;
`ifdef DIV_ERR_FLAGS_EN
          divz_d  = 1'b0;
          ovf_d   = 1'b0;
          if (Den == '0) begin
            state_d = DONE;
            coc_d   = '1;
            res_d   = Num;
            divz_d  = 1'b1;
          end else if (Signed && Num == {1'b1, {(WIDTH-1){1'b0}}} && Den == '1) begin
            state_d = DONE;
            coc_d   = Num;
            res_d   = '0;
            ovf_d   = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        accu_d = step_accu;
        quo_d  = step_quo;
        cont_d = cont_q - CW'(1);
        if (cont_q == '0) state_d = FIX;
      end
      FIX: begin
        coc_d   = (sgn_q && (snum_q ^ sden_q)) ? neg2c(quo_q) : quo_q;
        res_d   = (sgn_q && snum_q) ? neg2c(accu_q[WIDTH-1:0]) : accu_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; async reset aborts any in-flight divide.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q <= IDLE;
      cont_q  <= '0;
      sgn_q   <= 1'b0;
      snum_q  <= 1'b0;
      sden_q  <= 1'b0;
      coc_q   <= '0;
      res_q   <= '0;
`ifdef DIV_ERR_FLAGS_EN
      divz_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cont_q  <= cont_d;
      sgn_q   <= sgn_d;
      snum_q  <= snum_d;
      sden_q  <= sden_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
`ifdef DIV_ERR_FLAGS_EN
      divz_q  <= divz_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Working datapath registers; always reloaded at accept, so no reset needed.
  always_ff @(posedge CLK) begin
    accu_q <= accu_d;
    m_q    <= m_d;
    quo_q  <= quo_d;
  end

`ifndef DIV_ERR_FLAGS_EN
`ifndef SYNTHESIS
  // Without the flag path a zero divisor runs the normal algorithm; flag it in simulation.
  always @(posedge CLK) begin
    if (RSTa && accept && Den == '0) $error("divisor_radix_hs: divide by zero accepted");
  end
`endif
`endif

endmodule

// File: tb/tb_divisor_radix_hs.sv
// Bench for divisor_radix_hs: a 32-bit radix-2 instance and a 16-bit radix-16
// instance, directed steps, expected results queued at drive time.
module tb_divisor_radix_hs;

  logic        CLK = 1'b0;
  logic        RSTa = 1'b0;
  logic        Signed_i = 1'b0;
  logic [31:0] Num_i = '0, Den_i = '0;
  logic        v32 = 1'b0, v16 = 1'b0, out_ready = 1'b0;
  logic        rdy32, rdy16, ov32, ov16, dz32, dz16, of32, of16;
  logic [31:0] coc32, res32;
  logic [15:0] coc16, res16;
  logic        sel = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] c;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  divisor_radix_hs #(.WIDTH(32), .RADIX_BITS(1)) u32 (
    .CLK(CLK), .RSTa(RSTa), .in_valid(v32), .in_ready(rdy32), .Signed(Signed_i),
    .Num(Num_i), .Den(Den_i), .out_valid(ov32), .out_ready(out_ready),
    .Coc(coc32), .Res(res32), .DivZero(dz32), .Ovf(of32));

  divisor_radix_hs #(.WIDTH(16), .RADIX_BITS(4)) u16 (
    .CLK(CLK), .RSTa(RSTa), .in_valid(v16), .in_ready(rdy16), .Signed(Signed_i),
    .Num(Num_i[15:0]), .Den(Den_i[15:0]), .out_valid(ov16), .out_ready(out_ready),
    .Coc(coc16), .Res(res16), .DivZero(dz16), .Ovf(of16));

  logic [31:0] o_coc, o_res;
  logic        o_rdy, o_vld, o_dz, o_ov;
  assign o_coc = sel ? {16'h0, coc16} : coc32;
  assign o_res = sel ? {16'h0, res16} : res32;
  assign o_rdy = sel ? rdy16 : rdy32;
  assign o_vld = sel ? ov16 : ov32;
  assign o_dz  = sel ? dz16 : dz32;
  assign o_ov  = sel ? of16 : of32;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction: s/n/d operands, expected results, expected extra edges after
  // the accept edge before out_valid, and cycles of backpressure before out_ready.
  task automatic do_op(input logic which, input logic s, input logic [31:0] n, input logic [31:0] d,
                       input logic [31:0] ec, input logic [31:0] er, input logic edz, input logic eov,
                       input int exp_lat, input int hold);
    exp_t e;
    int   w;
    int   lat;
    sel = which;
    w = 0;
    #1;
    while (!o_rdy && w < 100) begin @(posedge CLK); #1; w++; end
    check("in_ready_before_accept", {31'b0, o_rdy}, 32'd1);
    Signed_i = s; Num_i = n; Den_i = d;
    v32 = (which == 1'b0);
    v16 = (which == 1'b1);
    sb.push_back('{c: ec, r: er, dz: edz, ov: eov});
    @(posedge CLK); #1;
    v32 = 1'b0; v16 = 1'b0;
    Signed_i = ~s; Num_i = $urandom; Den_i = $urandom | 32'h1;
    lat = 0;
    while (!o_vld && lat < 100) begin @(posedge CLK); #1; lat++; end
    check("latency", lat, exp_lat);
    check("in_ready_busy", {31'b0, o_rdy}, 32'd0);
    e = sb.pop_front();
    check("Coc", o_coc, e.c);
    check("Res", o_res, e.r);
    check("DivZero", {31'b0, o_dz}, {31'b0, e.dz});
    check("Ovf", {31'b0, o_ov}, {31'b0, e.ov});
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("hold_Coc", o_coc, e.c);
      check("hold_Res", o_res, e.r);
      check("hold_valid", {31'b0, o_vld}, 32'd1);
      check("hold_in_ready", {31'b0, o_rdy}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    check("valid_after_hs", {31'b0, o_vld}, 32'd0);
    check("in_ready_after_hs", {31'b0, o_rdy}, 32'd1);
  endtask

  initial begin
    #2;
    check("rst_in_ready", {31'b0, rdy32}, 32'd1);
    check("rst_out_valid", {31'b0, ov32}, 32'd0);
    check("rst_Coc", coc32, 32'd0);
    check("rst_Res", res32, 32'd0);
    check("rst_flags", {30'b0, dz32, of32}, 32'd0);
    check("rst_in_ready16", {31'b0, rdy16}, 32'd1);
    @(posedge CLK); #1;
    RSTa = 1'b1;
    @(posedge CLK); #1;

    do_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 0);
    do_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 0);
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 33, 0);
    // Backpressure, then a second pair offered straight after the handshake.
    do_op(1'b0, 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 33, 5);
    do_op(1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 0);
    do_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 33, 0);
`ifdef DIV_ERR_FLAGS_EN
    do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 0, 2);
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 0, 0);
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 0);
`else
    do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0, 33, 0);
`endif

    do_op(1'b1, 1'b0, 32'h0000FFFF, 32'h00000003, 32'h00005555, 32'd0, 1'b0, 1'b0, 5, 0);
    do_op(1'b1, 1'b1, 32'h00008001, 32'h00000010, 32'h0000F801, 32'h0000FFF1, 1'b0, 1'b0, 5, 1);

    // Reset in the middle of CALC on the 32-bit instance.
    sel = 1'b0;
    do_op(1'b0, 1'b0, 32'd50, 32'd4, 32'd12, 32'd2, 1'b0, 1'b0, 33, 0);
    Signed_i = 1'b0; Num_i = 32'd100; Den_i = 32'd7; v32 = 1'b1;
    @(posedge CLK); #1;
    v32 = 1'b0;
    repeat (10) @(posedge CLK);
    #1 RSTa = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, ov32}, 32'd0);
    check("midrst_in_ready", {31'b0, rdy32}, 32'd1);
    check("midrst_Coc", coc32, 32'd0);
    check("midrst_Res", res32, 32'd0);
    @(posedge CLK); #1;
    RSTa = 1'b1;
    @(posedge CLK); #1;
    check("postrst_valid", {31'b0, ov32}, 32'd0);
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
